// File: rtl/beta_pkg.sv
// Shared definitions for the BETA multi-cycle controller: opcodes, state and
// class encodings, write-data select codes and a small opcode classifier.
package beta_pkg;

    localparam logic [5:0] OP_LD         = 6'h18;
    localparam logic [5:0] OP_ST         = 6'h19;
    localparam logic [5:0] OP_JMP        = 6'h1B;
    localparam logic [5:0] OP_BEQ        = 6'h1C;
    localparam logic [5:0] OP_BNE        = 6'h1D;
    localparam logic [5:0] OP_LDR        = 6'h1F;
    localparam logic [5:0] OP_ALU_REG_LO = 6'h20;
    localparam logic [5:0] OP_ALU_LIT_LO = 6'h30;

    localparam logic [1:0] WDSEL_PC_INC = 2'd0;
    localparam logic [1:0] WDSEL_ALU    = 2'd1;
    localparam logic [1:0] WDSEL_MEM    = 2'd2;

    localparam logic [4:0] R_XP   = 5'd30;
    localparam logic [4:0] R_ZERO = 5'd31;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB
    } state_t;

    typedef enum logic [3:0] {
        CLS_ALU_REG,
        CLS_ALU_LIT,
        CLS_LD,
        CLS_ST,
        CLS_LDR,
        CLS_JMP,
        CLS_BEQ,
        CLS_BNE,
        CLS_ILLOP,
        CLS_IRQ
    } op_class_t;

    typedef enum logic [2:0] {
        PC_SEL_INC,
        PC_SEL_BEQ,
        PC_SEL_BNE,
        PC_SEL_JMP,
        PC_SEL_ILLOP,
        PC_SEL_XADDR
    } pc_sel_t;

    function automatic op_class_t classify(input logic [5:0] opcode);
        op_class_t c;
        c = CLS_ILLOP;
        if (opcode >= OP_ALU_LIT_LO)      c = CLS_ALU_LIT;
        else if (opcode >= OP_ALU_REG_LO) c = CLS_ALU_REG;
        else begin
            case (opcode)
                OP_LD:   c = CLS_LD;
                OP_ST:   c = CLS_ST;
                OP_LDR:  c = CLS_LDR;
                OP_JMP:  c = CLS_JMP;
                OP_BEQ:  c = CLS_BEQ;
                OP_BNE:  c = CLS_BNE;
                default: c = CLS_ILLOP;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/beta_pc_unit.sv
// BETA program counter: PC register, supervisor-preserving incrementer and
// the branch / JMP / trap target mux. RADATA is captured in EXEC for use in WB.
module beta_pc_unit
    import beta_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h8000_0000,
    parameter logic [31:0] ILLOP_ADDR = 32'h8000_0004,
    parameter logic [31:0] XADDR      = 32'h8000_0008
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        capture,
    input  logic        update,
    input  pc_sel_t     pc_sel,
    input  logic [15:0] lit,
    input  logic [31:0] ra_data,
    output logic [31:0] pc,
    output logic [31:0] pc_inc
);

    logic [31:0] ra_q;
    logic [30:0] br_low;
    logic [31:0] br_target;
    logic [31:0] jmp_target;
    logic [31:0] pc_next;

    assign pc_inc     = {pc[31], pc[30:0] + 31'd4};
    assign br_low     = pc_inc[30:0] + {{13{lit[15]}}, lit, 2'b00};
    assign br_target  = {pc[31], br_low};
    // JMP may drop the supervisor bit but never raise it
    assign jmp_target = {pc[31] & ra_q[31], ra_q[30:2], 2'b00};

    always_comb begin
        pc_next = pc_inc;
        case (pc_sel)
            PC_SEL_BEQ:   if (ra_q == 32'd0) pc_next = br_target;
            PC_SEL_BNE:   if (ra_q != 32'd0) pc_next = br_target;
            PC_SEL_JMP:   pc_next = jmp_target;
            PC_SEL_ILLOP: pc_next = {1'b1, ILLOP_ADDR[30:0]};
            PC_SEL_XADDR: pc_next = {1'b1, XADDR[30:0]};
            default:      pc_next = pc_inc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc   <= RESET_ADDR;
            ra_q <= 32'd0;
        end else begin
            if (capture) ra_q <= ra_data;
            if (update)  pc   <= pc_next;
        end
    end

endmodule

// File: rtl/beta_mc_ctl.sv
// BETA multi-cycle control sequencer and PC unit wrapper.
// Optional interrupt entry is enabled with the IRQ_SUPPORT_EN macro.
//
// state  | meaning
// FETCH  | IMEM_REQ high until IMEM_ACK, latch instruction
// DECODE | classify opcode, sample IRQ (when enabled)
// EXEC   | capture RADATA for branch/JMP, pick MEM or WB
// MEM    | hold MOE/MWR until DMEM_ACK
// WB     | register-file write (not ST), PC update
module beta_mc_ctl
    import beta_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h8000_0000,
    parameter logic [31:0] ILLOP_ADDR = 32'h8000_0004,
    parameter logic [31:0] XADDR      = 32'h8000_0008
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        IMEM_ACK,
    input  logic [31:0] IMEM_DATA,
    input  logic        DMEM_ACK,
    input  logic [31:0] RADATA,
    input  logic        IRQ,
    output logic        IMEM_REQ,
    output logic [31:0] PC,
    output logic [31:0] PC_INC,
    output logic [4:0]  RA,
    output logic [4:0]  RB,
    output logic [4:0]  RC,
    output logic        RA2SEL,
    output logic        WASEL,
    output logic        WERF,
    output logic        ASEL,
    output logic        BSEL,
    output logic [31:0] LIT,
    output logic [5:0]  ALUFN,
    output logic [1:0]  WDSEL,
    output logic        MOE,
    output logic        MWR
);

    state_t    state, state_next;
    logic [31:0] ir;
    logic      irq_q;
    op_class_t cls;
    pc_sel_t   pc_sel;
    logic      is_mem;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_FETCH;
            ir    <= 32'd0;
        end else begin
            state <= state_next;
            if (state == ST_FETCH && IMEM_ACK) ir <= IMEM_DATA;
        end
    end

`ifdef IRQ_SUPPORT_EN
    always_ff @(posedge CLK) begin
        if (RESET)                    irq_q <= 1'b0;
        else if (state == ST_DECODE)  irq_q <= IRQ & ~PC[31];
        else if (state == ST_FETCH)   irq_q <= 1'b0;
    end
`else
    logic irq_unused;
    assign irq_unused = IRQ;
    assign irq_q      = 1'b0;
`endif

    assign cls = irq_q ? CLS_IRQ : classify(ir[31:26]);
    assign RA  = ir[20:16];
    assign RB  = ir[15:11];
    assign RC  = ir[25:21];
    assign LIT = {{16{ir[15]}}, ir[15:0]};

    always_comb begin
        state_next = state;
        IMEM_REQ   = 1'b0;
        WERF       = 1'b0;
        MOE        = 1'b0;
        MWR        = 1'b0;
        RA2SEL     = 1'b0;
        WASEL      = 1'b0;
        ASEL       = 1'b0;
        BSEL       = 1'b0;
        ALUFN      = 6'd0;
        WDSEL      = WDSEL_PC_INC;
        pc_sel     = PC_SEL_INC;
        is_mem     = 1'b0;

        // selects stay low while fetching so a stale IR never leaks out
        if (state != ST_FETCH) begin
            case (cls)
                CLS_ALU_REG: begin ALUFN = ir[31:26]; WDSEL = WDSEL_ALU; end
                CLS_ALU_LIT: begin ALUFN = ir[31:26]; BSEL = 1'b1; WDSEL = WDSEL_ALU; end
                CLS_LD:      begin BSEL = 1'b1; WDSEL = WDSEL_MEM; is_mem = 1'b1; end
                CLS_LDR:     begin ASEL = 1'b1; BSEL = 1'b1; WDSEL = WDSEL_MEM; is_mem = 1'b1; end
                CLS_ST:      begin BSEL = 1'b1; RA2SEL = 1'b1; is_mem = 1'b1; end
                CLS_JMP:     pc_sel = PC_SEL_JMP;
                CLS_BEQ:     pc_sel = PC_SEL_BEQ;
                CLS_BNE:     pc_sel = PC_SEL_BNE;
                CLS_ILLOP:   begin WASEL = 1'b1; pc_sel = PC_SEL_ILLOP; end
                CLS_IRQ:     begin WASEL = 1'b1; pc_sel = PC_SEL_XADDR; end
                default:     ;
            endcase
        end

        case (state)
            ST_FETCH: begin
                IMEM_REQ = ~RESET;
                if (IMEM_ACK) state_next = ST_DECODE;
            end
            ST_DECODE: state_next = ST_EXEC;
            ST_EXEC:   state_next = is_mem ? ST_MEM : ST_WB;
            ST_MEM: begin
                MOE = (cls == CLS_LD) || (cls == CLS_LDR);
                MWR = (cls == CLS_ST);
                if (DMEM_ACK) state_next = ST_WB;
            end
            ST_WB: begin
                WERF       = (cls != CLS_ST);
                state_next = ST_FETCH;
            end
            default: state_next = ST_FETCH;
        endcase
    end

    beta_pc_unit #(
        .RESET_ADDR (RESET_ADDR),
        .ILLOP_ADDR (ILLOP_ADDR),
        .XADDR      (XADDR)
    ) u_pc (
        .clk     (CLK),
        .rst     (RESET),
        .capture (state == ST_EXEC),
        .update  (state == ST_WB),
        .pc_sel  (pc_sel),
        .lit     (ir[15:0]),
        .ra_data (RADATA),
        .pc      (PC),
        .pc_inc  (PC_INC)
    );

endmodule

// File: tb/tb_beta_mc_ctl.sv
// Directed plus randomized bench for beta_mc_ctl; expected behaviour comes
// from an instruction-level model of PC flow and write-back controls.
module tb_beta_mc_ctl;

    logic        CLK = 1'b0;
    logic        RESET, IMEM_ACK, DMEM_ACK, IRQ;
    logic [31:0] IMEM_DATA, RADATA;
    logic        IMEM_REQ, RA2SEL, WASEL, WERF, ASEL, BSEL, MOE, MWR;
    logic [31:0] PC, PC_INC, LIT;
    logic [4:0]  RA, RB, RC;
    logic [5:0]  ALUFN;
    logic [1:0]  WDSEL;

    beta_mc_ctl dut (
        .CLK(CLK), .RESET(RESET), .IMEM_ACK(IMEM_ACK), .IMEM_DATA(IMEM_DATA),
        .DMEM_ACK(DMEM_ACK), .RADATA(RADATA), .IRQ(IRQ), .IMEM_REQ(IMEM_REQ),
        .PC(PC), .PC_INC(PC_INC), .RA(RA), .RB(RB), .RC(RC), .RA2SEL(RA2SEL),
        .WASEL(WASEL), .WERF(WERF), .ASEL(ASEL), .BSEL(BSEL), .LIT(LIT),
        .ALUFN(ALUFN), .WDSEL(WDSEL), .MOE(MOE), .MWR(MWR)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    logic [31:0] mpc;

    localparam logic [31:0] JMP_I = {6'h1B, 5'd31, 5'd5, 16'h0000};
    localparam logic [31:0] ADDC_I = 32'hC041_0005;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic bit is_illegal(input logic [5:0] opc);
        return !(opc >= 6'h20 || opc == 6'h18 || opc == 6'h19 || opc == 6'h1B ||
                 opc == 6'h1C || opc == 6'h1D || opc == 6'h1F);
    endfunction

    function automatic logic [31:0] keep_sup(input logic [31:0] pc, input logic [31:0] v);
        return (v & 32'h7FFF_FFFF) | (pc & 32'h8000_0000);
    endfunction

    function automatic logic [31:0] model_next_pc(input logic [31:0] pc, input logic [31:0] instr,
                                                  input logic [31:0] ra, input bit irq_eff);
        logic [5:0]  opc;
        logic [31:0] inc, off;
        opc = instr[31:26];
        inc = keep_sup(pc, pc + 32'd4);
        off = {{16{instr[15]}}, instr[15:0]} << 2;
        if (irq_eff) return 32'h8000_0008;
        if (is_illegal(opc)) return 32'h8000_0004;
        if (opc == 6'h1B) return (ra & 32'h7FFF_FFFC) | (pc & ra & 32'h8000_0000);
        if (opc == 6'h1C) return (ra == 32'd0) ? keep_sup(pc, inc + off) : inc;
        if (opc == 6'h1D) return (ra != 32'd0) ? keep_sup(pc, inc + off) : inc;
        return inc;
    endfunction

    task automatic run_instr(input logic [31:0] instr, input logic [31:0] ra,
                             input int idly, input int ddly, input logic irq);
        logic [5:0]  opc;
        bit          irq_eff, trap, st, ld, mem, alu, ctl;
        logic [1:0]  wd;
        logic [31:0] npc, exp_inc;
        opc = instr[31:26];
`ifdef IRQ_SUPPORT_EN
        irq_eff = irq && !mpc[31];
`else
        irq_eff = 1'b0;
`endif
        trap    = irq_eff || is_illegal(opc);
        st      = !irq_eff && opc == 6'h19;
        ld      = !irq_eff && (opc == 6'h18 || opc == 6'h1F);
        mem     = st || ld;
        alu     = !trap && opc >= 6'h20;
        ctl     = !trap && (opc == 6'h1B || opc == 6'h1C || opc == 6'h1D);
        wd      = (trap || ctl) ? 2'd0 : alu ? 2'd1 : 2'd2;
        npc     = model_next_pc(mpc, instr, ra, irq_eff);
        exp_inc = keep_sup(mpc, mpc + 32'd4);
        IRQ     = irq;

        check("fetch_pc", PC, mpc);
        check1("fetch_req", IMEM_REQ, 1'b1);
        repeat (idly) begin
            tick();
            check1("fetch_wait_req", IMEM_REQ, 1'b1);
        end
        IMEM_ACK  = 1'b1;
        IMEM_DATA = instr;
        tick();
        IMEM_ACK  = 1'b0;
        IMEM_DATA = $urandom();

        check1("dec_req", IMEM_REQ, 1'b0);
        check1("dec_werf", WERF, 1'b0);
        check("dec_fields", {17'd0, RC, RA, RB}, {17'd0, instr[25:21], instr[20:16], instr[15:11]});
        check("dec_lit", LIT, {{16{instr[15]}}, instr[15:0]});
        RADATA = $urandom();
        tick();

        check("exec_strobes", {28'd0, WERF, MOE, MWR, IMEM_REQ}, 32'd0);
        RADATA = ra;
        tick();
        RADATA = $urandom();

        if (mem) begin
            for (int k = 0; k <= ddly; k++) begin
                DMEM_ACK = (k == ddly);
                check1("mem_moe", MOE, ld);
                check1("mem_mwr", MWR, st);
                check1("mem_ra2sel", RA2SEL, st);
                check1("mem_werf", WERF, 1'b0);
                tick();
            end
            DMEM_ACK = 1'b0;
        end

        check1("wb_werf", WERF, !st);
        check1("wb_wasel", WASEL, trap);
        if (!st) check("wb_wdsel", {30'd0, WDSEL}, {30'd0, wd});
        check1("wb_bsel", BSEL, !trap && (opc >= 6'h30 || opc == 6'h18 || opc == 6'h19 || opc == 6'h1F));
        check1("wb_asel", ASEL, !trap && opc == 6'h1F);
        check("wb_alufn", {26'd0, ALUFN}, alu ? {26'd0, opc} : 32'd0);
        check("wb_strobes", {29'd0, MOE, MWR, IMEM_REQ}, 32'd0);
        check("wb_pc", PC, mpc);
        check("wb_pc_inc", PC_INC, exp_inc);
        tick();
        check("next_pc", PC, npc);
        mpc = npc;
        IRQ = 1'b0;
    endtask

    initial begin
        logic [31:0] rnd, instr, ra;
        logic [5:0]  opc;
        int          pick;

        RESET = 1'b1; IMEM_ACK = 1'b0; DMEM_ACK = 1'b0; IRQ = 1'b0;
        IMEM_DATA = 32'd0; RADATA = 32'd0;
        tick();
        tick();
        check("rst_pc", PC, 32'h8000_0000);
        check("rst_strobes", {28'd0, IMEM_REQ, WERF, MOE, MWR}, 32'd0);
        check("rst_selects", {26'd0, RA2SEL, WASEL, ASEL, BSEL, WDSEL}, 32'd0);
        check("rst_ir", {2'd0, RA, RB, RC, ALUFN, 9'd0} | LIT, 32'd0);
        RESET = 1'b0;
        #1;
        check1("rst_release_req", IMEM_REQ, 1'b1);
        mpc = 32'h8000_0000;

        run_instr(ADDC_I, $urandom(), 1, 0, 1'b0);
        check("addc_next", mpc, 32'h8000_0004);
        run_instr(JMP_I, 32'h8000_0010, 0, 0, 1'b0);
        run_instr(32'h73E0_FFFE, 32'd0, 1, 0, 1'b0);
        check("beq_target", PC, 32'h8000_000C);
        run_instr(JMP_I, 32'h0000_0100, 0, 0, 1'b0);
        run_instr({6'h19, 5'd3, 5'd1, 16'h0010}, $urandom(), 1, 3, 1'b0);
        check("st_next", PC, 32'h0000_0104);
        run_instr(JMP_I, 32'h0000_0200, 0, 0, 1'b0);
        run_instr(32'h0000_0000, $urandom(), 0, 0, 1'b0);
        check("illop_next", PC, 32'h8000_0004);
        run_instr(JMP_I, 32'h8000_0020, 0, 0, 1'b0);
        run_instr(JMP_I, 32'h0000_0403, 2, 0, 1'b0);
        check("jmp_clear_sup", PC, 32'h0000_0400);
        run_instr(JMP_I, 32'h0000_0040, 0, 0, 1'b0);
        run_instr(JMP_I, 32'h8000_0000, 0, 0, 1'b0);
        check("jmp_no_raise", PC, 32'h0000_0000);

        run_instr(JMP_I, 32'h0000_0300, 0, 0, 1'b0);
        run_instr(ADDC_I, $urandom(), 0, 0, 1'b1);
        run_instr(32'h0400_0000, $urandom(), 0, 0, 1'b0);
        run_instr(ADDC_I, $urandom(), 0, 0, 1'b1);

        for (int n = 0; n < 150; n++) begin
            pick = $urandom_range(0, 9);
            case (pick)
                0, 1, 2: opc = 6'($urandom_range(32, 63));
                3:       opc = 6'h18;
                4:       opc = 6'h19;
                5:       opc = 6'h1F;
                6:       opc = 6'h1B;
                7:       opc = 6'h1C;
                8:       opc = 6'h1D;
                default: opc = 6'($urandom_range(0, 63));
            endcase
            rnd   = $urandom();
            instr = {opc, rnd[25:0]};
            ra    = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
            run_instr(instr, ra, $urandom_range(0, 2), $urandom_range(0, 3),
                      1'($urandom_range(0, 3) == 0));
        end

        IMEM_ACK = 1'b1; IMEM_DATA = {6'h19, 5'd2, 5'd4, 16'h0008};
        tick();
        IMEM_ACK = 1'b0;
        tick();
        tick();
        check1("abort_mwr_before", MWR, 1'b1);
        RESET = 1'b1;
        tick();
        check1("abort_mwr_after", MWR, 1'b0);
        check1("abort_req", IMEM_REQ, 1'b0);
        check("abort_pc", PC, 32'h8000_0000);
        RESET = 1'b0;
        #1;
        check1("abort_refetch", IMEM_REQ, 1'b1);
        mpc = 32'h8000_0000;
        run_instr(ADDC_I, $urandom(), 0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
